// File: rtl/fpu_pcpi_ctrl.sv
// PCPI sequencer for the single-precision FPU: decodes OP-FP fadd/fsub/fmul, issues them to the
// shared datapath and returns the result to rd. Optional WAIT watchdog: define FPU_CTRL_TIMEOUT_EN.
module fpu_pcpi_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clkIn,
  input  logic                  rstLowIn,
  input  logic                  pcpiValidIn,
  input  logic [31:0]           pcpiInstIn,
  input  logic [DATA_WIDTH-1:0] pcpiRs1In,
  input  logic [DATA_WIDTH-1:0] pcpiRs2In,
  output logic                  pcpiWrOut,
  output logic [DATA_WIDTH-1:0] pcpiRdOut,
  output logic                  pcpiWaitOut,
  output logic                  pcpiReadyOut,
  output logic                  opStartOut,
  output logic [1:0]            opSelOut,
  output logic [DATA_WIDTH-1:0] opAOut,
  output logic [DATA_WIDTH-1:0] opBOut,
  input  logic                  opDoneIn,
  input  logic [DATA_WIDTH-1:0] opResultIn,
  output logic                  timeoutOut
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [6:0] OPCODE_OP_FP = 7'b1010011;
  localparam logic [6:0] F7_ADD       = 7'b0000000;
  localparam logic [6:0] F7_SUB       = 7'b0000100;
  localparam logic [6:0] F7_MUL       = 7'b0001000;
  localparam logic [DATA_WIDTH-1:0] CANON_NAN = DATA_WIDTH'(32'h7FC00000);

  function automatic logic decode_hit(input logic [31:0] inst);
    logic f7_ok;
    case (inst[31:25])
      F7_ADD, F7_SUB, F7_MUL: f7_ok = 1'b1;
      default:                f7_ok = 1'b0;
    endcase
    return (inst[6:0] == OPCODE_OP_FP) && f7_ok;
  endfunction

  function automatic logic [1:0] decode_sel(input logic [6:0] funct7);
    logic [1:0] sel;
    case (funct7)
      F7_SUB:  sel = 2'b01;
      F7_MUL:  sel = 2'b10;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [1:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_post_resp;
  logic                  w_accept;
  logic                  w_expire;
  logic                  w_start;
  logic                  w_wait;
  logic                  w_ready;
  logic                  w_unused_bits;

  assign w_unused_bits = ^{pcpiInstIn[24:7], 8'(TIMEOUT_CYCLES)};

  // The core still drives a stale request in the cycle right after RESP; never accept there.
  assign w_accept = (r_state == S_IDLE) && pcpiValidIn && decode_hit(pcpiInstIn) && !r_post_resp;

  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ISSUE;
        else          w_next = S_IDLE;
      end
      S_ISSUE: begin
        if (!pcpiValidIn) w_next = S_DRAIN;
        else              w_next = S_WAIT;
      end
      S_WAIT: begin
        // An abort coinciding with done needs no drain: the datapath is already free.
        if (!pcpiValidIn)               w_next = opDoneIn ? S_IDLE : S_DRAIN;
        else if (opDoneIn || w_expire)  w_next = S_RESP;
        else                            w_next = S_WAIT;
      end
      S_RESP: w_next = S_IDLE;
      S_DRAIN: begin
        if (opDoneIn) w_next = S_IDLE;
        else          w_next = S_DRAIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_wait  = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      S_ISSUE: begin
        w_start = 1'b1;
        w_wait  = 1'b1;
      end
      S_WAIT:  w_wait  = 1'b1;
      S_RESP:  w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      r_op_a      <= {DATA_WIDTH{1'b0}};
      r_op_b      <= {DATA_WIDTH{1'b0}};
      r_sel       <= 2'b00;
      r_result    <= {DATA_WIDTH{1'b0}};
      r_post_resp <= 1'b0;
    end else begin
      r_post_resp <= (r_state == S_RESP);
      if (w_accept) begin
        r_op_a <= pcpiRs1In;
        r_op_b <= pcpiRs2In;
        r_sel  <= decode_sel(pcpiInstIn[31:25]);
      end
      if ((r_state == S_WAIT) && pcpiValidIn) begin
        if (opDoneIn)      r_result <= opResultIn;
        else if (w_expire) r_result <= CANON_NAN;
      end
    end
  end

`ifdef FPU_CTRL_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  assign w_expire = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Counts WAIT cycles of the current instruction; the flag is sticky until reset.
  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept)                r_wait_cnt <= 8'd0;
      else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + 8'd1;
      if ((r_state == S_WAIT) && pcpiValidIn && !opDoneIn && w_expire) r_timeout <= 1'b1;
    end
  end

  assign timeoutOut = r_timeout;
`else
  assign w_expire   = 1'b0;
  assign timeoutOut = 1'b0;
`endif

  assign opStartOut   = w_start;
  assign pcpiWaitOut  = w_wait;
  assign pcpiReadyOut = w_ready;
  assign pcpiWrOut    = w_ready;
  assign pcpiRdOut    = r_result;
  assign opSelOut     = r_sel;
  assign opAOut       = r_op_a;
  assign opBOut       = r_op_b;

endmodule

// File: doc/fpu_pcpi_ctrl.md
# fpu_pcpi_ctrl

PCPI-side sequencer for the single-precision FPU execution unit. Decodes OP-FP instructions presented by the picorv32 core on PCPI and latches the operands. Issues a one-cycle start to the shared arithmetic datapath, waits for its completion and returns the result to the core's integer register file. Sits between the picorv32 PCPI port and the FPU add/sub/mult datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- TIMEOUT_CYCLES, 64, max WAIT cycles before forced response (only with FPU_CTRL_TIMEOUT_EN); legal range 2..255

Ports:
- clkIn  in  1  system clock; all state on rising edge
- rstLowIn  in  1  asynchronous, active-low reset
- pcpiValidIn  in  1  core presents instruction
- pcpiInstIn  in  32  instruction word
- pcpiRs1In  in  DATA_WIDTH  operand A
- pcpiRs2In  in  DATA_WIDTH  operand B
- pcpiWrOut  out  1  write pcpiRdOut to rd (valid with pcpiReadyOut)
- pcpiRdOut  out  DATA_WIDTH  result
- pcpiWaitOut  out  1  instruction claimed, in progress
- pcpiReadyOut  out  1  one-cycle completion strobe
- opStartOut  out  1  one-cycle start to datapath
- opSelOut  out  2  00 add, 01 sub, 10 mult
- opAOut, opBOut  out  DATA_WIDTH  latched operands, stable ISSUE through RESP
- opDoneIn  in  1  datapath result valid strobe
- opResultIn  in  DATA_WIDTH  datapath result, sampled with opDoneIn
- timeoutOut  out  1  sticky: a timeout occurred since reset

## Operation
- Decode: opcode [6:0]=7'b1010011; funct7 [31:25]: 7'b0000000 add, 7'b0000100 sub, 7'b0001000 mult. rm, rs/rd fields ignored. Any other word: not claimed; pcpiWaitOut stays 0, core traps on its own timeout.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: pcpiValidIn && decode hit -> latch rs1/rs2/sel -> ISSUE.
- ISSUE (1 cycle): opStartOut=1, pcpiWaitOut=1 -> WAIT.
- WAIT: pcpiWaitOut=1; opDoneIn=1 -> latch opResultIn -> RESP. Cycle counter increments per WAIT cycle, cleared on entering ISSUE.
- RESP (1 cycle): pcpiReadyOut=1, pcpiWrOut=1, pcpiRdOut=latched result, pcpiWaitOut=0 -> IDLE.
- Abort: pcpiValidIn low while in ISSUE or WAIT -> DRAIN; no ready issued. DRAIN waits for opDoneIn (result discarded) -> IDLE; pcpiWaitOut=0 in DRAIN; new requests ignored until IDLE.
- opDoneIn ignored in IDLE, ISSUE, RESP.
- Reset (any time, incl. mid-operation): state IDLE; all outputs 0; latches, counter, timeoutOut cleared. Datapath must be reset by the same rstLowIn.

## Timing
- Request sampled at edge N in IDLE -> ISSUE during N..N+1 (opStartOut, pcpiWaitOut high after N) -> WAIT after N+1.
- Datapath may raise opDoneIn no earlier than the cycle after opStartOut.
- opDoneIn sampled at edge M in WAIT -> pcpiReadyOut/pcpiWrOut high for exactly one cycle after M.
- Total: acceptance to ready = 2 + L cycles, L = datapath cycles from start to done (L>=1).
- pcpiRdOut holds last result in IDLE (0 after reset).
- Core drops pcpiValidIn on the edge ending RESP; IDLE does not re-accept a request in the cycle immediately following RESP.

## Configuration
- FPU_CTRL_TIMEOUT_EN defined: if WAIT counter reaches TIMEOUT_CYCLES without opDoneIn -> RESP with pcpiRdOut=32'h7FC00000, pcpiWrOut=1; timeoutOut set (sticky). opDoneIn in the same cycle as expiry wins (normal result, no flag). Late opDoneIn arriving after the forced response is ignored.
- Undefined: no counter; WAIT holds indefinitely; timeoutOut tied 0.

## Test plan
- Reset: rstLowIn low mid-WAIT -> all outputs 0 immediately (async); after release, IDLE, pcpiRdOut=0.
- fadd.s 0x00310253, rs1=0x3F800000, rs2=0x40000000, model L=3 returns 0x40400000 -> opSelOut=00, opStartOut one cycle, pcpiReadyOut+pcpiWrOut one cycle, 5 cycles after acceptance, rd=0x40400000.
- fsub.s 0x08310253 and fmul.s 0x10310253 back-to-back -> opSelOut 01 then 10, no second accept in the cycle after RESP, results match model.
- Unsupported word 0x02310233 (mul) with pcpiValidIn held 20 cycles -> pcpiWaitOut, opStartOut, pcpiReadyOut remain 0.
- Abort: drop pcpiValidIn in WAIT, model done 4 cycles later -> no pcpiReadyOut; new request accepted only after done; DRAIN passes.
- With FPU_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, model never done -> ready after 8 WAIT cycles, rd=0x7FC00000, timeoutOut=1 and stays set; repeat with done on expiry cycle -> real result, no flag.
